// File: rtl/rand_rot_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : rand_rot_dispenser
// Brief   : Serves one fresh randomness word as NUM_WORDS byte-rotated copies
//           over valid/ready streams. Optional macro RAND_ROT_LEFT_EN makes the
//           rotation go left instead of right.
// Revision: 1.0 - initial release
// ============================================================================
module rand_rot_dispenser #(
  parameter int WIDTH     = 216,
  parameter int STEP      = 8,
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, data_rot;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Pure wiring permutation: bits of a single word only, never mixed with another.
`ifdef RAND_ROT_LEFT_EN
  assign data_rot = {data_q[WIDTH-STEP-1:0], data_q[WIDTH-1:WIDTH-STEP]};
`else
  assign data_rot = {data_q[STEP-1:0], data_q[WIDTH-1:STEP]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          idx_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        out_valid = 1'b1;
        out_last  = (idx_q == LAST_IDX);
        in_ready  = out_ready && out_last;
        if (out_ready) begin
          if (!out_last) begin
            data_d = data_rot;
            idx_d  = idx_q + 1'b1;
          end else if (in_valid) begin
            // Reload during the final transfer so the stream has no bubble.
            data_d = in_data;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = data_q;
  assign out_idx  = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_rot_dispenser.sv
`default_nettype none
// Directed testbench for rand_rot_dispenser: handshake, rotation sequence,
// stalls, back-to-back loads and mid-word reset.
module tb_rand_rot_dispenser;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [215:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [215:0] out_data;
  logic [2:0]   out_idx;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  logic [215:0] word_a;
  logic [215:0] word_b;
  logic [215:0] word_b1;

  rand_rot_dispenser #(
    .WIDTH(216), .STEP(8), .NUM_WORDS(8), .IDX_W(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word A has byte k = k; after idx rotations byte k = (k +/- idx) mod 27.
  function automatic logic [215:0] exp_a(input int idx);
    logic [215:0] w;
    w = '0;
    for (int k = 0; k < 27; k++) begin
`ifdef RAND_ROT_LEFT_EN
      w[k*8 +: 8] = 8'((k + 27 - idx) % 27);
`else
      w[k*8 +: 8] = 8'((k + idx) % 27);
`endif
    end
    return w;
  endfunction

  task automatic load(input logic [215:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", {215'd0, out_valid}, 216'd0);
  endtask

  initial begin
    word_a = exp_a(0);
    word_b = {27{8'hA5}};
    word_b[7:0] = 8'h3C;
    word_b1 = {27{8'hA5}};
`ifdef RAND_ROT_LEFT_EN
    word_b1[15:8] = 8'h3C;
`else
    word_b1[215:208] = 8'h3C;
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {215'd0, out_valid}, 216'd0);
    chk("rst_out_idx",   {213'd0, out_idx},   216'd0);
    chk("rst_out_last",  {215'd0, out_last},  216'd0);
    chk("rst_out_data",  out_data,            216'd0);
    chk("rst_in_ready",  {215'd0, in_ready},  216'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full sequence with consumer always ready
    out_ready = 1'b1;
    chk("t1_in_ready_idle", {215'd0, in_ready}, 216'd1);
    load(word_a);
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", {215'd0, out_valid}, 216'd1);
      chk("t1_idx",   {213'd0, out_idx},   216'(i));
      chk("t1_data",  out_data,            exp_a(i));
      chk("t1_last",  {215'd0, out_last},  216'(i == 7));
      @(negedge clk);
    end
    chk("t1_valid_after", {215'd0, out_valid}, 216'd0);
    chk("t1_in_ready_after", {215'd0, in_ready}, 216'd1);

    // 2: out_ready pattern 1,0,0,1,0,0,...
    load(word_a);
    begin
      int cnt, c;
      cnt = 0; c = 0;
      while (cnt < 8 && c < 40) begin
        out_ready = (c % 3 == 0);
        chk("t2_valid", {215'd0, out_valid}, 216'd1);
        chk("t2_idx",   {213'd0, out_idx},   216'(cnt));
        chk("t2_data",  out_data,            exp_a(cnt));
        chk("t2_last",  {215'd0, out_last},  216'(cnt == 7));
        if (out_ready) cnt++;
        c++;
        @(negedge clk);
      end
      chk("t2_count", 216'(cnt), 216'd8);
      chk("t2_valid_after", {215'd0, out_valid}, 216'd0);
    end

    // 3: back-to-back load during the last transfer
    out_ready = 1'b1;
    load(word_a);
    in_valid = 1'b1;
    in_data  = word_b;
    for (int i = 0; i < 8; i++) begin
      chk("t3_in_ready", {215'd0, in_ready}, 216'(i == 7));
      chk("t3_data_a",   out_data,           exp_a(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_valid_b", {215'd0, out_valid}, 216'd1);
    chk("t3_idx_b",   {213'd0, out_idx},   216'd0);
    chk("t3_data_b0", out_data,            word_b);
    @(negedge clk);
    chk("t3_data_b1", out_data,            word_b1);
    drain();

    // 4: reset in the middle of a word
    out_ready = 1'b1;
    load(word_a);
    repeat (3) @(negedge clk);
    chk("t4_idx3", {213'd0, out_idx}, 216'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_valid", {215'd0, out_valid}, 216'd0);
    chk("t4_in_ready", {215'd0, in_ready}, 216'd1);
    chk("t4_idx", {213'd0, out_idx}, 216'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_valid_idle", {215'd0, out_valid}, 216'd0);
    load(word_a);
    chk("t4_reload_idx",  {213'd0, out_idx}, 216'd0);
    chk("t4_reload_data", out_data,          exp_a(0));
    drain();

    // 5: input offered while stalled mid-word is ignored
    out_ready = 1'b1;
    load(word_a);
    repeat (2) @(negedge clk);
    chk("t5_idx2", {213'd0, out_idx}, 216'd2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = word_b;
    chk("t5_in_ready", {215'd0, in_ready}, 216'd0);
    @(negedge clk);
    chk("t5_hold_idx",  {213'd0, out_idx}, 216'd2);
    chk("t5_hold_data", out_data,          exp_a(2));
    chk("t5_in_ready2", {215'd0, in_ready}, 216'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_next_idx",  {213'd0, out_idx}, 216'd3);
    chk("t5_next_data", out_data,          exp_a(3));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
